// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types and constants for the data-memory dump engine.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

  localparam int DUMP_FIFO_DEPTH = 2;
  localparam int DUMP_CNT_W      = $clog2(DUMP_FIFO_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/dump_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dump_fifo
// Purpose  : Small synchronous FIFO of {addr, data} words; head is always visible.
// Revision : 1.0
// ============================================================================
module dump_fifo
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DUMP_CNT_W-1:0] count,
  output logic [ADDR_W-1:0]     head_addr,
  output logic [DATA_W-1:0]     head_data
);

  localparam int PTR_W = $clog2(DUMP_FIFO_DEPTH);

  logic [ADDR_W+DATA_W-1:0] r_mem [DUMP_FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [DUMP_CNT_W-1:0]    r_count;
  logic                     w_do_push;
  logic                     w_do_pop;

  assign full      = (r_count == DUMP_CNT_W'(DUMP_FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  // A pop frees the slot in the same cycle, so push while full is accepted then.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign {head_addr, head_data} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DUMP_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= {push_addr, push_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + DUMP_CNT_W'(1);
        2'b01:   r_count <= r_count - DUMP_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_dumper.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_dumper
// Purpose  : Halts the core, reads a word range of data memory, streams it out.
// Revision : 1.0
// ============================================================================
module data_mem_dumper
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              core_halt_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              dout_valid_o,
  output logic [DATA_W-1:0] dout_data_o,
  output logic [ADDR_W-1:0] dout_addr_o,
  input  logic              dout_ready_i
);

  localparam int FREE_W = DUMP_CNT_W + 1;

  dump_state_t           r_state;
  dump_state_t           w_next_state;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic [ADDR_W:0]       r_rd_left;
  logic [ADDR_W:0]       r_out_left;
  logic                  r_inflight;
  logic [ADDR_W-1:0]     r_inflight_addr;
  logic                  w_full;
  logic                  w_empty;
  logic [DUMP_CNT_W-1:0] w_count;
  logic [FREE_W-1:0]     w_room;
  logic [FREE_W-1:0]     w_free;
  logic                  w_xfer;
  logic                  w_issue;

  assign dout_valid_o = !w_empty;
  assign w_xfer       = dout_valid_o && dout_ready_i;
  // Count a same-cycle pop as free space so a steady stream runs at one word/cycle.
  assign w_room  = w_full ? '0 : (FREE_W'(DUMP_FIFO_DEPTH) - {1'b0, w_count});
  assign w_free  = w_room + FREE_W'(w_xfer);
  assign w_issue = (r_state == READ) && (r_rd_left != '0) && (w_free > FREE_W'(r_inflight));

  assign mem_rd_en_o = w_issue;
  assign mem_addr_o  = r_rd_addr;
  assign core_halt_o = busy_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_next_state = (count_i == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (w_issue && (r_rd_left == (ADDR_W+1)'(1))) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_out_left == '0) || (w_xfer && (r_out_left == (ADDR_W+1)'(1)))) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        done_o       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr       <= '0;
      r_rd_left       <= '0;
      r_out_left      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_rd_addr;
      end
      if ((r_state == IDLE) && start_i) begin
        r_rd_addr  <= base_i;
        r_rd_left  <= count_i;
        r_out_left <= count_i;
      end else begin
        if (w_issue) begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
          r_rd_left <= r_rd_left - (ADDR_W+1)'(1);
        end
        if (w_xfer && (r_out_left != '0)) begin
          r_out_left <= r_out_left - (ADDR_W+1)'(1);
        end
      end
    end
  end

  dump_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_addr (r_inflight_addr),
    .push_data (mem_rd_data_i),
    .pop       (w_xfer),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head_addr (dout_addr_o),
    .head_data (dout_data_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_dumper
// Purpose  : Directed self-checking bench with a queue-based stream model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_dumper;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_i = '0;
  logic [ADDR_W:0]   count_i = '0;
  logic              busy_o, done_o, core_halt_o, mem_rd_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rd_data_i = '0;
  logic              dout_valid_o;
  logic [DATA_W-1:0] dout_data_o;
  logic [ADDR_W-1:0] dout_addr_o;
  logic              dout_ready_i = 1'b0;

  data_mem_dumper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .base_i        (base_i),
    .count_i       (count_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .core_halt_o   (core_halt_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .dout_valid_o  (dout_valid_o),
    .dout_data_o   (dout_data_o),
    .dout_addr_o   (dout_addr_o),
    .dout_ready_i  (dout_ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory with one-cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_rd_en_o) mem_rd_data_i <= mem[mem_addr_o];

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } item_t;

  item_t expq[$];
  int checks = 0;
  int errors = 0;
  int reads, xfers, valid_cnt;
  int first_cyc, last_cyc;
  logic first_seen;
  logic [ADDR_W-1:0] first_a, last_a, prev_a;
  logic [DATA_W-1:0] first_d, last_d, prev_d;
  logic prev_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream checker: every transfer must be the next word the model predicts.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("halt_eq_busy", 64'(core_halt_o), 64'(busy_o));
      if (prev_stall) begin
        chk("stable_valid", 64'(dout_valid_o), 64'd1);
        chk("stable_addr", 64'(dout_addr_o), 64'(prev_a));
        chk("stable_data", 64'(dout_data_o), 64'(prev_d));
      end
      if (dout_valid_o) valid_cnt++;
      if (mem_rd_en_o) reads++;
      if (dout_valid_o && dout_ready_i) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got addr %0d data %0h, required no word", dout_addr_o, dout_data_o);
        end else begin
          item_t e;
          e = expq.pop_front();
          chk("xfer_addr", 64'(dout_addr_o), 64'(e.a));
          chk("xfer_data", 64'(dout_data_o), 64'(e.d));
        end
        if (!first_seen) begin
          first_seen = 1'b1;
          first_a    = dout_addr_o;
          first_d    = dout_data_o;
          first_cyc  = cyc;
        end
        last_a   = dout_addr_o;
        last_d   = dout_data_o;
        last_cyc = cyc;
        xfers++;
      end
      prev_stall = dout_valid_o && !dout_ready_i;
      prev_a     = dout_addr_o;
      prev_d     = dout_data_o;
    end
  end

  function automatic logic ready_for(input int mode, input int k);
    int pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    case (mode)
      1:       return pat[k % 8] != 0;
      2:       return k > 20;
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_stats();
    reads = 0; xfers = 0; valid_cnt = 0; first_seen = 1'b0;
    first_cyc = -1; last_cyc = -1;
  endtask

  task automatic kick(input int b, input int n, input int mode, output int sc);
    item_t it;
    expq.delete();
    for (int i = 0; i < n; i++) begin
      it.a = ADDR_W'(b + i);
      it.d = mem[it.a];
      expq.push_back(it);
    end
    @(posedge clk); #1;
    clear_stats();
    base_i = ADDR_W'(b); count_i = (ADDR_W+1)'(n); start_i = 1'b1;
    dout_ready_i = ready_for(mode, 0);
    sc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_dump(input int b, input int n, input int mode, input int budget,
                          output int sc, output int done_k);
    kick(b, n, mode, sc);
    done_k = -1;
    for (int k = 1; k <= budget; k++) begin
      dout_ready_i = ready_for(mode, k);
      @(negedge clk);
      if (k == 1) begin
        chk("busy_c1", 64'(busy_o), 64'd1);
        chk("rd_en_c1", 64'(mem_rd_en_o), 64'(n != 0));
      end
      if (mode == 2 && k == 20) begin
        chk("reads_while_stalled", 64'(reads), 64'd2);
        chk("valid_while_stalled", 64'(dout_valid_o), 64'd1);
      end
      if (done_o) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_k < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o within %0d cycles, required a done pulse", budget);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_done", 64'(busy_o), 64'd0);
    chk("done_one_cycle", 64'(done_o), 64'd0);
    chk("all_words", 64'(expq.size()), 64'd0);
    chk("xfer_count", 64'(xfers), 64'(n));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_halt"}, 64'(core_halt_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_rden"}, 64'(mem_rd_en_o), 64'd0);
    chk({tag, "_valid"}, 64'(dout_valid_o), 64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, "_ddata"}, 64'(dout_data_o), 64'd0);
    chk({tag, "_daddr"}, 64'(dout_addr_o), 64'd0);
  endtask

  initial begin
    int sc, dk;
    logic saw_done;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i * 3 + 100);
    for (int i = 0; i < 10; i++) mem[i] = DATA_W'(10 - i);
    clear_stats();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Full-rate dump of 10 words.
    run_dump(0, 10, 0, 40, sc, dk);
    chk("t1_done_cycle", 64'(dk), 64'd13);
    chk("t1_first_cycle", 64'(first_cyc - sc), 64'd3);
    chk("t1_last_cycle", 64'(last_cyc - sc), 64'd12);
    chk("t1_first_addr", 64'(first_a), 64'd0);
    chk("t1_first_data", 64'(first_d), 64'd10);
    chk("t1_last_addr", 64'(last_a), 64'd9);
    chk("t1_last_data", 64'(last_d), 64'd1);
    chk("t1_valid_cycles", 64'(valid_cnt), 64'd10);

    // Toggling ready.
    run_dump(2, 3, 1, 60, sc, dk);
    chk("t2_first_addr", 64'(first_a), 64'd2);
    chk("t2_first_data", 64'(first_d), 64'd8);
    chk("t2_last_addr", 64'(last_a), 64'd4);
    chk("t2_last_data", 64'(last_d), 64'd6);

    // Address wrap at the top of memory.
    mem[DEPTH-2] = 32'hA;
    mem[DEPTH-1] = 32'hB;
    run_dump(DEPTH - 2, 4, 0, 40, sc, dk);
    chk("t3_first_addr", 64'(first_a), 64'(DEPTH - 2));
    chk("t3_first_data", 64'(first_d), 64'hA);
    chk("t3_last_addr", 64'(last_a), 64'd1);
    chk("t3_last_data", 64'(last_d), 64'd9);
    chk("t3_done_cycle", 64'(dk), 64'd7);

    // Empty dump.
    run_dump(5, 0, 0, 10, sc, dk);
    chk("t4_done_cycle", 64'(dk), 64'd1);
    chk("t4_reads", 64'(reads), 64'd0);
    chk("t4_valid_cycles", 64'(valid_cnt), 64'd0);

    // Consumer stalled for 20 cycles.
    run_dump(0, 5, 2, 60, sc, dk);
    chk("t5_reads", 64'(reads), 64'd5);
    chk("t5_last_data", 64'(last_d), 64'd6);

    // Reset in mid-dump after three transfers.
    kick(0, 10, 0, sc);
    for (int k = 1; k <= 30 && xfers < 3; k++) begin
      @(negedge clk); #1;
    end
    chk("t6_three_xfers", 64'(xfers), 64'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk); #1 rst = 1'b0;
    expq.delete();
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_o || mem_rd_en_o || busy_o) saw_done = 1'b1;
    end
    chk("t6_quiet_after_reset", 64'(saw_done), 64'd0);
    run_dump(0, 2, 0, 20, sc, dk);
    chk("t6_first_data", 64'(first_d), 64'd10);
    chk("t6_last_addr", 64'(last_a), 64'd1);
    chk("t6_last_data", 64'(last_d), 64'd9);
    chk("t6_done_cycle", 64'(dk), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_dumper.md
# data_mem_dumper

Hardware readback engine for the MIPS data memory. On command, it halts the core, reads a contiguous range of `data_mem_ff` words through a dedicated read port, and streams them out over a valid/ready interface. It is the read-side counterpart of bench/boot preloading, so memory contents can be checked through a port instead of hierarchical peeks. It sits beside `DataMemory`, next to `MIPS_core`, and owns the core halt line while active.

## Interface

Parameters:
- `ADDR_W`, 10: word-address width of data memory (`DATA_MEM_DEPTH` = 2**ADDR_W).
- `DATA_W`, 32: data word width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock.
  - `rst`, in, 1: synchronous active-high reset.
- Command:
  - `start_i`, in, 1: begin a dump; sampled only in IDLE.
  - `base_i`, in, ADDR_W: first word address.
  - `count_i`, in, ADDR_W+1: number of words to dump.
- Status:
  - `busy_o`, out, 1: high from the cycle after an accepted start until done.
  - `done_o`, out, 1: one-cycle pulse when the dump completes.
  - `core_halt_o`, out, 1: equal to `busy_o`; stalls `MIPS_core`.
- Memory read port:
  - `mem_rd_en_o`, out, 1: read request.
  - `mem_addr_o`, out, ADDR_W: word address.
  - `mem_rd_data_i`, in, DATA_W: read data, valid exactly 1 cycle after `mem_rd_en_o`.
- Output stream:
  - `dout_valid_o`, out, 1: stream word valid.
  - `dout_data_o`, out, DATA_W: stream word.
  - `dout_addr_o`, out, ADDR_W: address of the stream word.
  - `dout_ready_i`, in, 1: consumer accepts.

## Operation

- FSM states are IDLE, READ, DRAIN and DONE.
  - IDLE: on `start_i`, latch `base_i` into `rd_addr` and `count_i` into `rd_left` and `out_left`. If `count_i`==0, go to DONE. Otherwise go to READ.
  - READ: issue a read when `rd_left`>0 and free FIFO slots exceed the in-flight read (0/1). Each issue increments `rd_addr` (modulo 2**ADDR_W, wrap to 0) and decrements `rd_left`. Go to DRAIN when `rd_left` reaches 0.
  - DRAIN: no reads. Go to DONE when `out_left` reaches 0.
  - DONE: `done_o`=1 for one cycle, then IDLE.
- Returned read data is written into a 2-entry FIFO together with its address.
- The FIFO head drives `dout_*`. A transfer happens on `dout_valid_o && dout_ready_i`, which decrements `out_left`.
- Handshake rules:
  - Once `dout_valid_o` is high, it and `dout_data_o`/`dout_addr_o` stay stable until the transfer.
  - `dout_ready_i` may toggle freely.
- Simultaneous FIFO push and pop is legal at any fill level, including full.
- `start_i` while busy is ignored and not queued.
- Reset at any time:
  - State goes to IDLE and the FIFO is emptied.
  - The in-flight read is discarded.
  - No `done_o` is produced.

## Timing

- Reset values:
  - `busy_o`, `core_halt_o`, `done_o`, `mem_rd_en_o` and `dout_valid_o` are 0.
  - `mem_addr_o`, `dout_data_o` and `dout_addr_o` are 0.
- Start at cycle 0 (accepted, IDLE):
  - Cycle 1: `busy_o`=1 and the first `mem_rd_en_o`=1.
  - Cycle 2: data returns.
  - Cycle 3: `dout_valid_o`=1.
- Throughput with `dout_ready_i` held high is 1 word/cycle.
- Latency from start to the last transfer is count+2 cycles; `done_o` pulses the cycle after the last transfer.
- `busy_o` falls in the cycle after `done_o`.
- With `dout_ready_i` low the FIFO fills. At most 2 entries are held and there is no overflow: reads stall because in-flight plus occupancy never exceeds 2.
- `count_i`==0: `done_o` at cycle 1, no reads, and `busy_o` high only during DONE.

## Structure

- The following go in `mips_pkg`:
  - `dump_state_t` enum (IDLE, READ, DRAIN, DONE).
  - `DUMP_FIFO_DEPTH`=2.
- Sub-module `dump_fifo`:
  - 2-entry synchronous FIFO of {addr, data} with synchronous active-high `rst`.
  - Ports: push, pop, full, empty, count.
- The top level holds the FSM, the address/count counters and the in-flight flag.

## Test plan

- Preload mem[0..9]=10,9,…,1. Start with base=0, count=10 and ready held high -> stream (0,10),(1,9)…(9,1) on consecutive cycles; `done_o` one cycle after (9,1).
- Same preload, base=2, count=3, ready toggling 1,0,0,1,0,1… -> exactly (2,8),(3,7),(4,6) in order, each held stable while stalled, with no drops or duplicates.
- Base=2**ADDR_W−2, count=4, mem[top−1]=0xA, mem[top]=0xB, mem[0]=10, mem[1]=9 -> addresses wrap: (top−1,0xA),(top,0xB),(0,10),(1,9).
- Count=0 -> `done_o` at cycle 1, `mem_rd_en_o` never asserted, `dout_valid_o` never asserted.
- Ready held low for 20 cycles after start (count=5) -> exactly 2 reads issued and FIFO full; after ready rises, all 5 words are delivered.
- Assert `rst` in mid-dump after 3 transfers -> next cycle all outputs are at reset values and no `done_o` occurs; a new start with base=0, count=2 yields (0,10),(1,9).
